// File: rtl/sram_controller.sv
// Processor-side initiator for a 16-bit asynchronous SRAM: splits each 32-bit
// load/store into a low and a high half-word access, stalling the pipeline via ready.
module sram_controller #(
    parameter int unsigned BASE_ADDR     = 1024,
    parameter int unsigned ACCESS_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready,
    inout  wire  [15:0] SRAM_DQ,
    output logic [17:0] SRAM_ADDR,
    output logic        SRAM_UB_N,
    output logic        SRAM_LB_N,
    output logic        SRAM_WE_N,
    output logic        SRAM_CE_N,
    output logic        SRAM_OE_N
);

    localparam int CW = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(ACCESS_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WR_LO = 3'd1,
        WR_HI = 3'd2,
        RD_LO = 3'd3,
        RD_HI = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t      state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic [16:0] widx_reg, widx_next;
    logic [31:0] wdata_reg, wdata_next;
    logic [31:0] read_data_reg, read_data_next;
    logic [17:0] sram_addr_reg, sram_addr_next;
    logic        we_n_reg, we_n_next;
    logic        dq_oe_reg, dq_oe_next;
    logic [15:0] dq_out_reg, dq_out_next;

    logic [31:0] off;
    logic        phase_last;
    logic        unused_off_bits;

    // Offsets beyond the 2^19-byte SRAM window wrap through the bit selection.
    assign off             = address - BASE_ADDR;
    assign unused_off_bits = ^{off[31:19], off[1:0]};
    assign phase_last      = (cnt_reg == CNT_LAST);

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        widx_next      = widx_reg;
        wdata_next     = wdata_reg;
        read_data_next = read_data_reg;

        case (state_reg)
            IDLE: begin
                cnt_next = '0;
                if (wr_en) begin
                    state_next = WR_LO;
                    widx_next  = off[18:2];
                    wdata_next = write_data;
                end else if (rd_en) begin
                    state_next = RD_LO;
                    widx_next  = off[18:2];
                end
            end
            WR_LO, WR_HI, RD_LO, RD_HI: begin
                if (phase_last) begin
                    cnt_next = '0;
                    case (state_reg)
                        WR_LO:   state_next = WR_HI;
                        RD_LO:   state_next = RD_HI;
                        default: state_next = DONE;
                    endcase
                    if (state_reg == RD_LO) read_data_next[15:0]  = SRAM_DQ;
                    if (state_reg == RD_HI) read_data_next[31:16] = SRAM_DQ;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Bus signals are registered from the upcoming state so they change cleanly on edges.
    always_comb begin
        sram_addr_next = sram_addr_reg;
        we_n_next      = 1'b1;
        dq_oe_next     = 1'b0;
        dq_out_next    = dq_out_reg;

        case (state_next)
            WR_LO: begin
                sram_addr_next = {widx_next, 1'b0};
                we_n_next      = 1'b0;
                dq_oe_next     = 1'b1;
                dq_out_next    = wdata_next[15:0];
            end
            WR_HI: begin
                sram_addr_next = {widx_next, 1'b1};
                we_n_next      = 1'b0;
                dq_oe_next     = 1'b1;
                dq_out_next    = wdata_next[31:16];
            end
            RD_LO:   sram_addr_next = {widx_next, 1'b0};
            RD_HI:   sram_addr_next = {widx_next, 1'b1};
            default: sram_addr_next = sram_addr_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            widx_reg      <= '0;
            wdata_reg     <= '0;
            read_data_reg <= '0;
            sram_addr_reg <= '0;
            we_n_reg      <= 1'b1;
            dq_oe_reg     <= 1'b0;
            dq_out_reg    <= '0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            widx_reg      <= widx_next;
            wdata_reg     <= wdata_next;
            read_data_reg <= read_data_next;
            sram_addr_reg <= sram_addr_next;
            we_n_reg      <= we_n_next;
            dq_oe_reg     <= dq_oe_next;
            dq_out_reg    <= dq_out_next;
        end
    end

    always_comb begin
        case (state_reg)
            IDLE:    ready = !(wr_en || rd_en);
            DONE:    ready = 1'b1;
            default: ready = 1'b0;
        endcase
    end

    assign SRAM_DQ   = dq_oe_reg ? dq_out_reg : 16'bz;
    assign SRAM_ADDR = sram_addr_reg;
    assign SRAM_WE_N = we_n_reg;
    assign read_data = read_data_reg;
    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;
    assign SRAM_CE_N = 1'b0;
    assign SRAM_OE_N = 1'b0;

endmodule

// File: tb/tb_sram_controller.sv
// Bench for sram_controller: an SRAM responder on the bus, a cycle-offset model of
// each access checked every cycle, and directed accesses with literal expectations.
module tb_sram_controller;

    localparam int unsigned BASE = 1024;
    localparam int unsigned AC   = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en, rd_en;
    logic [31:0] address, write_data;
    logic [31:0] read_data;
    logic        ready;
    wire  [15:0] sram_dq;
    logic [17:0] sram_addr;
    logic        sram_ub_n, sram_lb_n, sram_we_n, sram_ce_n, sram_oe_n;

    int checks = 0;
    int errors = 0;

    logic [15:0] resp_mem  [0:262143];
    logic [15:0] model_mem [0:262143];

    sram_controller #(.BASE_ADDR(BASE), .ACCESS_CYCLES(AC)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en),
        .address(address), .write_data(write_data),
        .read_data(read_data), .ready(ready),
        .SRAM_DQ(sram_dq), .SRAM_ADDR(sram_addr),
        .SRAM_UB_N(sram_ub_n), .SRAM_LB_N(sram_lb_n), .SRAM_WE_N(sram_we_n),
        .SRAM_CE_N(sram_ce_n), .SRAM_OE_N(sram_oe_n)
    );

    always #5 clk = ~clk;

    // Responder: OE is tied active, so the SRAM drives whenever WE_N is high.
    assign sram_dq = sram_we_n ? resp_mem[sram_addr] : 16'bz;
    always @(posedge clk) if (!sram_we_n) resp_mem[sram_addr] <= sram_dq;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Model: an accepted request is followed by cycles k=1..2*AC of bus phases
    // (low half first) and one ready cycle at k=2*AC+1.
    logic        model_on = 1'b0;
    logic        m_busy = 1'b0;
    int          m_k = 0;
    logic        m_is_wr = 1'b0;
    logic [16:0] m_widx = '0;
    logic [31:0] m_wdata = '0;
    logic [31:0] exp_rd = '0;
    logic        m_phase, m_hi;
    logic [17:0] m_ha;
    logic [31:0] m_off;

    always @(negedge clk) begin
        if (model_on) begin
            m_phase = m_busy && (m_k <= 2 * AC);
            m_hi    = (m_k > AC);
            m_ha    = {m_widx, m_hi};
            chk("ready", {31'd0, ready}, {31'd0, m_busy ? !m_phase : !(wr_en || rd_en)});
            chk("read_data", read_data, exp_rd);
            chk("we_n", {31'd0, sram_we_n}, {31'd0, m_phase ? !m_is_wr : 1'b1});
            if (m_phase) begin
                chk("sram_addr", {14'd0, sram_addr}, {14'd0, m_ha});
                if (m_is_wr)
                    chk("dq_write", {16'd0, sram_dq}, {16'd0, m_hi ? m_wdata[31:16] : m_wdata[15:0]});
            end
            if (!(m_phase && m_is_wr))
                chk("dq_released", {16'd0, sram_dq}, {16'd0, resp_mem[sram_addr]});

            if (m_phase && m_is_wr)
                model_mem[m_ha] = m_hi ? m_wdata[31:16] : m_wdata[15:0];
            if (m_phase && !m_is_wr && m_k == AC)     exp_rd[15:0]  = model_mem[m_ha];
            if (m_phase && !m_is_wr && m_k == 2 * AC) exp_rd[31:16] = model_mem[m_ha];

            if (rst) begin
                m_busy = 1'b0;
                exp_rd = '0;
            end else if (m_busy) begin
                if (m_k == 2 * AC + 1) m_busy = 1'b0;
                else m_k++;
            end else if (wr_en || rd_en) begin
                m_busy  = 1'b1;
                m_k     = 1;
                m_is_wr = wr_en;
                m_off   = address - BASE;
                m_widx  = m_off[18:2];
                m_wdata = write_data;
            end
        end
    end

    // Called just after a rising edge; returns just after the edge that ends DONE.
    task automatic access(input logic w, input logic r, input logic [31:0] a,
                          input logic [31:0] d, input string name);
        int lat;
        wr_en = w; rd_en = r; address = a; write_data = d;
        lat = 0;
        @(negedge clk);
        while (!ready && lat < 40) begin
            lat++;
            @(negedge clk);
        end
        @(posedge clk); #1;
        wr_en = 1'b0; rd_en = 1'b0;
        chk({name, "_stall_cycles"}, lat, 32'd5);
        $display("access %s wr=%0b rd=%0b addr=%0d wdata=%h -> read_data=%h stall=%0d",
                 name, w, r, a, d, read_data, lat);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 262144; i++) begin
            resp_mem[i]  = '0;
            model_mem[i] = '0;
        end
        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; address = '0; write_data = '0;
        @(posedge clk); #1;
        model_on = 1'b1;
        @(negedge clk);
        chk("reset_sram_addr", {14'd0, sram_addr}, 32'd0);
        chk("reset_we_n", {31'd0, sram_we_n}, 32'd1);
        chk("reset_ready", {31'd0, ready}, 32'd1);
        chk("reset_read_data", read_data, 32'd0);
        chk("tied_pins", {27'd0, sram_ub_n, sram_lb_n, sram_ce_n, sram_oe_n, 1'b0}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Store 0xDEADBEEF at 1024, checked cycle by cycle.
        wr_en = 1'b1; address = 32'd1024; write_data = 32'hDEADBEEF;
        @(negedge clk);
        chk("st_c0_ready", {31'd0, ready}, 32'd0);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (c <= 4) begin
                chk("st_addr", {14'd0, sram_addr}, (c <= 2) ? 32'd0 : 32'd1);
                chk("st_dq", {16'd0, sram_dq}, (c <= 2) ? 32'h0000BEEF : 32'h0000DEAD);
                chk("st_we_n", {31'd0, sram_we_n}, 32'd0);
            end else begin
                chk("st_c5_ready", {31'd0, ready}, 32'd1);
                chk("st_c5_we_n", {31'd0, sram_we_n}, 32'd1);
            end
        end
        @(posedge clk); #1;
        wr_en = 1'b0;
        $display("access store0 wr=1 rd=0 addr=1024 wdata=deadbeef -> cycle-checked");

        access(1'b0, 1'b1, 32'd1024, 32'h0, "load0");
        chk("load0_data", read_data, 32'hDEADBEEF);

        access(1'b1, 1'b0, 32'd1036, 32'h12345678, "store1036");
        chk("mem6", {16'd0, resp_mem[6]}, 32'h00005678);
        chk("mem7", {16'd0, resp_mem[7]}, 32'h00001234);
        access(1'b0, 1'b1, 32'd1038, 32'h0, "load1038");
        chk("load1038_data", read_data, 32'h12345678);

        access(1'b1, 1'b1, 32'd1028, 32'hAAAA5555, "both1028");
        chk("both_read_data_kept", read_data, 32'h12345678);
        chk("mem2", {16'd0, resp_mem[2]}, 32'h00005555);
        chk("mem3", {16'd0, resp_mem[3]}, 32'h0000AAAA);

        // Back-to-back: the load is presented in the IDLE cycle right after DONE.
        access(1'b1, 1'b0, 32'd1040, 32'hCAFEF00D, "b2b_store");
        access(1'b0, 1'b1, 32'd1040, 32'h0, "b2b_load");
        chk("b2b_data", read_data, 32'hCAFEF00D);

        // Offset wrap: 1024 + 2^19 aliases word 0; address 0 maps near the top.
        access(1'b1, 1'b0, 32'd1024 + 32'h80000, 32'h0BADF00D, "wrap_store");
        access(1'b0, 1'b1, 32'd1024, 32'h0, "wrap_load");
        chk("wrap_data", read_data, 32'h0BADF00D);
        access(1'b1, 1'b0, 32'd0, 32'h55AA33CC, "store_addr0");
        chk("mem_3fe00", {16'd0, resp_mem[18'h3FE00]}, 32'h000033CC);

        // Reset during cycle 3 of a store aborts it with no DONE cycle.
        wr_en = 1'b1; address = 32'd1044; write_data = 32'h11112222;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1; wr_en = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("abort_we_n", {31'd0, sram_we_n}, 32'd1);
        chk("abort_ready", {31'd0, ready}, 32'd1);
        chk("abort_read_data", read_data, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        $display("access abort wr=1 addr=1044 rst in cycle 3 -> ready=%0b read_data=%h", ready, read_data);
        repeat (6) @(posedge clk);
        #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sram_controller.md
Name: sram_controller

Overview:
- Processor-side initiator for the off-chip 16-bit SRAM. Sits in the memory stage of the ARM pipeline and is the counterpart of the SRAM responder model.
- Converts one 32-bit load or store into two sequential 16-bit SRAM accesses.
- Holds `ready` low while the access is in progress, so the pipeline freezes until the access completes.

Parameters:
- BASE_ADDR, 1024: byte address that maps to SRAM word 0; subtracted from `address`.
- ACCESS_CYCLES, 2: system clock cycles each 16-bit half-access is held on the bus (min 1).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- wr_en  in  1  store request; held until `ready` is sampled high.
- rd_en  in  1  load request; held until `ready` is sampled high.
- address  in  32  byte address of the access.
- write_data  in  32  store data.
- read_data  out  32  load data; valid while `ready` is high in DONE after a read.
- ready  out  1  high = no access pending (pipeline may advance).
- SRAM_DQ  inout  16  data bus; driven only in write phases, otherwise Z.
- SRAM_ADDR  out  18  SRAM half-word address.
- SRAM_UB_N  out  1  tied 0.
- SRAM_LB_N  out  1  tied 0.
- SRAM_WE_N  out  1  write enable, active low.
- SRAM_CE_N  out  1  tied 0.
- SRAM_OE_N  out  1  tied 0.

Behaviour:
- Reset (synchronous):
  - state=IDLE, phase counter=0, read_data=0, SRAM_ADDR=0, SRAM_WE_N=1, SRAM_DQ=Z.
- Address mapping:
  - off = address − BASE_ADDR, 32-bit modular arithmetic.
  - widx = off[18:2]; off[1:0] ignored.
  - Low half: SRAM_ADDR = {widx,1'b0}, carries bits [15:0].
  - High half: SRAM_ADDR = {widx,1'b1}, carries bits [31:16].
- States: IDLE, WR_LO, WR_HI, RD_LO, RD_HI, DONE.
- IDLE:
  - wr_en → WR_LO; else rd_en → RD_LO.
  - Both asserted: write wins, the read is ignored.
  - Address and write_data are latched internally on the accepting edge.
- Each LO/HI phase lasts exactly ACCESS_CYCLES cycles (counter 0..ACCESS_CYCLES−1). LO → HI, HI → DONE.
- DONE lasts one cycle, then returns to IDLE.
  - A request present in that IDLE cycle is a new access.
- Write phases:
  - SRAM_ADDR and SRAM_DQ are driven with the latched half for the whole phase.
  - SRAM_WE_N=0 during the phase and returns to 1 in DONE/IDLE.
- Read phases:
  - SRAM_WE_N=1, SRAM_DQ=Z.
  - SRAM_DQ is sampled on the last cycle of the phase into read_data[15:0] (LO) or read_data[31:16] (HI).
  - read_data holds its value until the next read overwrites it.
- ready (combinational from state and requests):
  - 1 in IDLE with no request.
  - 0 in IDLE with a request.
  - 0 in all phase states.
  - 1 in DONE.
- Latency: request asserted in cycle 0 (IDLE) → ready=1 in cycle 2·ACCESS_CYCLES+1 (cycle 5 at the default).
- Request changes mid-access are ignored; the latched values are used.
- rst during any phase:
  - aborts the access at the next edge: WE_N=1, DQ=Z, state IDLE.
  - no DONE pulse is produced.
  - A partially written word is not rolled back.
- Offsets ≥ 2^19 wrap silently through the widx bit selection.

Test Plan:
- Store: wr_en, address=1024, write_data=0xDEADBEEF.
  - Cycles 1–2: SRAM_ADDR=0, DQ=0xBEEF, WE_N=0.
  - Cycles 3–4: SRAM_ADDR=1, DQ=0xDEAD, WE_N=0.
  - Cycle 5: ready=1, WE_N=1.
- Load back: rd_en, address=1024 → DQ=Z throughout; ready=1 in cycle 5 with read_data=0xDEADBEEF.
- Address map: store 0x12345678 at address=1036 → writes to SRAM addresses 6 and 7. A load at 1038 (off[1:0] ignored) returns 0x12345678.
- Simultaneous wr_en=rd_en=1, address=1028 → write sequence to SRAM addresses 2/3; read_data unchanged.
- Back-to-back: store, then load held immediately after the DONE cycle → the second access begins in the following IDLE cycle; ready is low for 5 cycles and high for 1 cycle for each access.
- rst asserted in cycle 3 of a store → next edge: WE_N=1, DQ=Z, ready=1 (IDLE, request dropped), no DONE cycle; read_data=0.
